// File: rtl/axis_pingpong_capture.sv
// AXI-Stream capture into a two-bank (ping-pong) RAM buffer.
// Accepted words are written one cycle later to {bank, index}. A frame is
// closed by T_LAST or by filling the bank; the bank is then marked full and
// writing continues in the other bank. A bank stays full until the consumer
// pulses its Bank_Release bit. When the bank being written is full, T_READY
// drops and the stream is held back, so no data is lost.
module axis_pingpong_capture #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  reset_b,
  input  logic [DATA_W-1:0]     T_DATA,
  input  logic                  T_VALID,
  input  logic                  T_LAST,
  output logic                  T_READY,
  output logic                  Ram_We,
  output logic [DEPTH_LOG2:0]   Ram_Addr,
  output logic [DATA_W-1:0]     Ram_Data,
  output logic                  Frame_Done,
  output logic                  Frame_Bank,
  output logic [DEPTH_LOG2:0]   Frame_Len,
  output logic [1:0]            Bank_Full,
  input  logic [1:0]            Bank_Release
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic [DEPTH_LOG2-1:0] INDEX_MAX = '1;
  localparam logic [DEPTH_LOG2-1:0] INDEX_ONE = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   LEN_ONE   = (DEPTH_LOG2 + 1)'(1);

  state_t                  state_reg, state_next;
  logic                    wr_bank_reg, wr_bank_next;
  logic [DEPTH_LOG2-1:0]   index_reg, index_next;
  logic [1:0]              bank_full_reg, bank_full_next;

  logic                    ram_we_reg;
  logic [DEPTH_LOG2:0]     ram_addr_reg;
  logic [DATA_W-1:0]       ram_data_reg;
  logic                    frame_done_reg;
  logic                    frame_bank_reg;
  logic [DEPTH_LOG2:0]     frame_len_reg;

  logic                    ready;
  logic                    accept;
  logic                    close;

  // Handshake qualifiers; ready comes from registered state only.
  assign accept = T_VALID & ready;
  assign close  = accept & (T_LAST | (index_reg == INDEX_MAX));

  // Per-bank full flag: a close on that bank sets it and beats a release in
  // the same edge (the bank was not yet full, so the release is moot).
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    localparam logic BANK_ID = 1'(gi);
    assign bank_full_next[gi] = (close && (wr_bank_reg == BANK_ID)) ? 1'b1 :
                                Bank_Release[gi]                  ? 1'b0 :
                                bank_full_reg[gi];
  end

  // Write pointer advance: toggle bank and rewind on close, else count.
  always_comb begin
    wr_bank_next = wr_bank_reg;
    index_next   = index_reg;
    if (close) begin
      wr_bank_next = ~wr_bank_reg;
      index_next   = '0;
    end else if (accept) begin
      index_next   = index_reg + INDEX_ONE;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; WAIT means the bank we would write next is full.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE, ST_FILL: begin
        if (close) begin
          state_next = bank_full_next[~wr_bank_reg] ? ST_WAIT : ST_IDLE;
        end else if (accept) begin
          state_next = ST_FILL;
        end
      end
      ST_WAIT: begin
        if (Bank_Release[wr_bank_reg]) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output logic from state: stall the stream only while waiting.
  always_comb begin
    ready = (state_reg != ST_WAIT);
  end

  // Write pointer and bank-full registers.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      wr_bank_reg   <= 1'b0;
      index_reg     <= '0;
      bank_full_reg <= 2'b00;
    end else begin
      wr_bank_reg   <= wr_bank_next;
      index_reg     <= index_next;
      bank_full_reg <= bank_full_next;
    end
  end

  // RAM write port and frame report, one cycle after acceptance.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      ram_we_reg     <= 1'b0;
      ram_addr_reg   <= '0;
      ram_data_reg   <= '0;
      frame_done_reg <= 1'b0;
      frame_bank_reg <= 1'b0;
      frame_len_reg  <= '0;
    end else begin
      ram_we_reg     <= accept;
      frame_done_reg <= close;
      if (accept) begin
        ram_addr_reg <= {wr_bank_reg, index_reg};
        ram_data_reg <= T_DATA;
      end
      if (close) begin
        frame_bank_reg <= wr_bank_reg;
        // Widened by one bit so a full bank reports 2^DEPTH_LOG2.
        frame_len_reg  <= {1'b0, index_reg} + LEN_ONE;
      end
    end
  end

  assign T_READY    = ready;
  assign Ram_We     = ram_we_reg;
  assign Ram_Addr   = ram_addr_reg;
  assign Ram_Data   = ram_data_reg;
  assign Frame_Done = frame_done_reg;
  assign Frame_Bank = frame_bank_reg;
  assign Frame_Len  = frame_len_reg;
  assign Bank_Full  = bank_full_reg;

endmodule

// File: tb/tb_axis_pingpong_capture.sv
// Bench for axis_pingpong_capture: directed scenarios followed by random
// traffic, all checked every cycle against a behavioural model of the
// capture buffer (bank/index counters and full flags as plain integers).
module tb_axis_pingpong_capture;

  localparam int DATA_W     = 32;
  localparam int DEPTH_LOG2 = 6;
  localparam int DEPTH      = 64;

  logic              clk = 1'b0;
  logic              reset_b = 1'b0;
  logic [DATA_W-1:0] T_DATA = '0;
  logic              T_VALID = 1'b0;
  logic              T_LAST = 1'b0;
  logic              T_READY;
  logic              Ram_We;
  logic [DEPTH_LOG2:0] Ram_Addr;
  logic [DATA_W-1:0] Ram_Data;
  logic              Frame_Done;
  logic              Frame_Bank;
  logic [DEPTH_LOG2:0] Frame_Len;
  logic [1:0]        Bank_Full;
  logic [1:0]        Bank_Release = 2'b00;

  axis_pingpong_capture #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk          (clk),
    .reset_b      (reset_b),
    .T_DATA       (T_DATA),
    .T_VALID      (T_VALID),
    .T_LAST       (T_LAST),
    .T_READY      (T_READY),
    .Ram_We       (Ram_We),
    .Ram_Addr     (Ram_Addr),
    .Ram_Data     (Ram_Data),
    .Frame_Done   (Frame_Done),
    .Frame_Bank   (Frame_Bank),
    .Frame_Len    (Frame_Len),
    .Bank_Full    (Bank_Full),
    .Bank_Release (Bank_Release)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_frames = 0;

  // Behavioural model state.
  int          m_bank;
  int          m_idx;
  logic [1:0]  m_full;
  logic        exp_we, exp_done, exp_fbank, exp_ready;
  logic [6:0]  exp_addr, exp_flen;
  logic [31:0] exp_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_bank    = 0;
    m_idx     = 0;
    m_full    = 2'b00;
    exp_we    = 1'b0;
    exp_addr  = '0;
    exp_data  = '0;
    exp_done  = 1'b0;
    exp_fbank = 1'b0;
    exp_flen  = '0;
    exp_ready = 1'b1;
  endtask

  task automatic compare_outputs();
    chk("t_ready",   64'(T_READY),   64'(exp_ready));
    chk("ram_we",    64'(Ram_We),    64'(exp_we));
    chk("ram_addr",  64'(Ram_Addr),  64'(exp_addr));
    chk("ram_data",  64'(Ram_Data),  64'(exp_data));
    chk("frame_done",64'(Frame_Done),64'(exp_done));
    chk("bank_full", 64'(Bank_Full), 64'(m_full));
    if (exp_done) begin
      chk("frame_bank", 64'(Frame_Bank), 64'(exp_fbank));
      chk("frame_len",  64'(Frame_Len),  64'(exp_flen));
    end
  endtask

  // Drive one cycle of inputs (called just after a falling edge), advance the
  // model across the next rising edge, then compare at the following fall.
  task automatic cycle(input logic v, input logic l, input logic [31:0] d,
                       input logic [1:0] rel);
    bit acc;
    bit cls;
    T_VALID      = v;
    T_LAST       = l;
    T_DATA       = d;
    Bank_Release = rel;
    acc      = v && !m_full[m_bank];
    cls      = acc && (l || (m_idx == DEPTH - 1));
    exp_we   = acc;
    exp_done = 1'b0;
    if (acc) begin
      exp_addr = 7'(m_bank * DEPTH + m_idx);
      exp_data = d;
    end
    for (int i = 0; i < 2; i++) begin
      if (rel[i]) m_full[i] = 1'b0;
    end
    if (cls) begin
      m_full[m_bank] = 1'b1;
      exp_done  = 1'b1;
      exp_fbank = m_bank[0];
      exp_flen  = 7'(m_idx + 1);
      m_bank    = 1 - m_bank;
      m_idx     = 0;
    end else if (acc) begin
      m_idx++;
    end
    exp_ready = !m_full[m_bank];
    @(negedge clk);
    compare_outputs();
    if (exp_done) begin
      n_frames++;
      $display("frame %0d: bank=%0d len=%0d last_addr=%0d full=%b",
               n_frames, exp_fbank, exp_flen, exp_addr, m_full);
    end
  endtask

  initial begin
    model_reset();
    #2;
    compare_outputs();
    @(negedge clk);
    reset_b = 1'b1;

    // 64 words fill bank 0 without T_LAST.
    for (int i = 0; i < 64; i++) cycle(1'b1, 1'b0, 32'(i), 2'b00);
    chk("model_len64", 64'(exp_flen), 64'd64);
    chk("len64",  64'(Frame_Len), 64'd64);
    chk("bank64", 64'(Frame_Bank), 64'd0);
    chk("addr63", 64'(Ram_Addr), 64'd63);
    chk("full01", 64'(Bank_Full), 64'd1);
    chk("ready_after64", 64'(T_READY), 64'd1);

    // 5-word frame into bank 1, then held-off stream.
    for (int i = 0; i < 5; i++) cycle(1'b1, (i == 4), 32'(100 + i), 2'b00);
    chk("model_len5", 64'(exp_flen), 64'd5);
    chk("addr68", 64'(Ram_Addr), 64'd68);
    chk("len5",   64'(Frame_Len), 64'd5);
    chk("bank5",  64'(Frame_Bank), 64'd1);
    chk("full11", 64'(Bank_Full), 64'd3);
    chk("ready0", 64'(T_READY), 64'd0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 32'hdead, 2'b00);
      chk("stall_no_we", 64'(Ram_We), 64'd0);
    end

    // Release bank 0, next word lands at address 0.
    cycle(1'b0, 1'b0, 32'h0, 2'b01);
    chk("rel_ready", 64'(T_READY), 64'd1);
    chk("rel_full",  64'(Bank_Full), 64'd2);
    cycle(1'b1, 1'b0, 32'h200, 2'b00);
    chk("addr0", 64'(Ram_Addr), 64'd0);
    chk("data200", 64'(Ram_Data), 64'h200);

    // Close bank 0 while releasing bank 1 on the same edge.
    cycle(1'b1, 1'b1, 32'h201, 2'b10);
    chk("closerel_full",  64'(Bank_Full), 64'd1);
    chk("closerel_ready", 64'(T_READY), 64'd1);
    chk("closerel_len",   64'(Frame_Len), 64'd2);
    cycle(1'b0, 1'b0, 32'h0, 2'b01);

    // 1-word frames.
    cycle(1'b1, 1'b1, 32'h300, 2'b00);
    chk("addr64", 64'(Ram_Addr), 64'd64);
    chk("len1",   64'(Frame_Len), 64'd1);
    chk("len1_ready", 64'(T_READY), 64'd1);
    cycle(1'b1, 1'b1, 32'h301, 2'b00);
    chk("len1b_full", 64'(Bank_Full), 64'd3);
    cycle(1'b0, 1'b0, 32'h0, 2'b11);
    chk("relboth", 64'(Bank_Full), 64'd0);

    // Releasing the bank being closed on the same edge is ignored.
    cycle(1'b1, 1'b1, 32'h400, 2'b00);
    cycle(1'b1, 1'b1, 32'h401, 2'b01);
    chk("selfrel_full", 64'(Bank_Full), 64'd3);
    chk("selfrel_ready", 64'(T_READY), 64'd0);

    // Asynchronous reset mid-frame at index 30.
    cycle(1'b0, 1'b0, 32'h0, 2'b11);
    for (int i = 0; i < 30; i++) cycle(1'b1, 1'b0, 32'(600 + i), 2'b00);
    chk("addr93", 64'(Ram_Addr), 64'd93);
    #3;
    reset_b = 1'b0;
    #1;
    chk("arst_ready", 64'(T_READY), 64'd1);
    chk("arst_we",    64'(Ram_We), 64'd0);
    chk("arst_addr",  64'(Ram_Addr), 64'd0);
    chk("arst_data",  64'(Ram_Data), 64'd0);
    chk("arst_done",  64'(Frame_Done), 64'd0);
    chk("arst_fbank", 64'(Frame_Bank), 64'd0);
    chk("arst_flen",  64'(Frame_Len), 64'd0);
    chk("arst_full",  64'(Bank_Full), 64'd0);
    model_reset();
    T_VALID = 1'b0;
    @(negedge clk);
    compare_outputs();
    reset_b = 1'b1;
    cycle(1'b1, 1'b0, 32'h500, 2'b00);
    chk("post_rst_addr", 64'(Ram_Addr), 64'd0);
    chk("post_rst_data", 64'(Ram_Data), 64'h500);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic v, l;
      logic [1:0] rel;
      v      = ($urandom_range(0, 3) != 0);
      l      = ($urandom_range(0, 9) == 0);
      rel[0] = ($urandom_range(0, 7) == 0);
      rel[1] = ($urandom_range(0, 7) == 0);
      cycle(v, l, $urandom, rel);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
